// File: rtl/fifo_rd_framer.sv
// fifo_rd_framer: pops a FWFT FIFO and emits header/length/payload/checksum frames on a valid/ready stream
`timescale 1ns/1ps
module fifo_rd_framer #(
  parameter int DSIZE = 8,
  parameter int PKT_LEN = 16,
  parameter logic [DSIZE-1:0] HDR_BYTE = 8'hA5,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             en,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eof,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [2:0] {IDLE, HDR, LEN, PAY, CSUM} state_t;
  state_t state, state_n;
  logic [DSIZE-1:0] sum, cnt, ld_data;
  logic slot_free, load, last;
  always_comb begin
    slot_free = !out_valid || out_ready;
    rinc = state == PAY && slot_free && !rempty && !rrst;
    last = cnt == DSIZE'(PKT_LEN - 1);
    load = rinc || (slot_free && (state == HDR || state == LEN || state == CSUM));
    ld_data = state == HDR ? HDR_BYTE : state == LEN ? DSIZE'(PKT_LEN) : state == CSUM ? -sum : rdata;
    busy = state != IDLE;
    state_n = state == IDLE ? (en && !rempty ? HDR : IDLE) :
              state == HDR  ? (slot_free ? LEN : HDR) :
              state == LEN  ? (slot_free ? PAY : LEN) :
              state == PAY  ? (rinc && last ? CSUM : PAY) :
                              (slot_free ? IDLE : CSUM);
  end
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sof <= 1'b0;
      out_eof <= 1'b0;
      sum <= '0;
      cnt <= '0;
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        out_valid <= 1'b1;
        out_data <= ld_data;
        out_sof <= state == HDR;
        out_eof <= state == CSUM;
      end else if (slot_free) out_valid <= 1'b0;
      if (rinc) begin
        sum <= sum + rdata;
        cnt <= cnt + 1'b1;
      end
      if (state == CSUM && slot_free) begin
        sum <= '0;
        cnt <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (state == PAY && rempty && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_rd_framer.sv
// tb_fifo_rd_framer: directed self-checking bench for fifo_rd_framer with PKT_LEN=4
`timescale 1ns/1ps
module tb_fifo_rd_framer;
  logic clk = 1'b0;
  logic rrst, en, rempty, rinc, out_valid, out_ready, out_sof, out_eof, busy;
  logic [7:0] rdata, out_data;
  logic [15:0] frame_cnt, stall_cnt;
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0, rd_ptr = 8'd0;
  int errors = 0, checks = 0, rinc_n = 0, bad_empty = 0, bad_pop = 0, bad_hold = 0;
  int base, r0;
  logic [9:0] rx[$], exp_q[$];
  logic hold = 1'b0;
  logic [9:0] h = '0;
  bit bp = 0;
  fifo_rd_framer #(.DSIZE(8), .PKT_LEN(4), .HDR_BYTE(8'hA5), .CNT_W(16)) dut (
    .rclk(clk), .rrst(rrst), .en(en), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .out_eof(out_eof), .busy(busy), .frame_cnt(frame_cnt), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  assign rempty = wr_ptr == rd_ptr;
  assign rdata = mem[rd_ptr];
  always @(posedge clk) if (rinc) rd_ptr <= rd_ptr + 8'd1;
  always @(negedge clk) begin
    if (rrst) hold <= 1'b0;
    else begin
      if (rinc) rinc_n <= rinc_n + 1;
      if (rinc && rempty) bad_empty <= bad_empty + 1;
      if (rinc && out_valid && !out_ready) bad_pop <= bad_pop + 1;
      if (hold && !(out_valid && {out_sof, out_eof, out_data} == h)) bad_hold <= bad_hold + 1;
      if (out_valid && out_ready) rx.push_back({out_sof, out_eof, out_data});
      hold <= out_valid && !out_ready;
      h <= {out_sof, out_eof, out_data};
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask
  task automatic push4(input logic [7:0] a, b, c, d);
    push(a); push(b); push(c); push(d);
  endtask
  task automatic do_reset;
    rrst = 1'b1;
    wr_ptr = rd_ptr;
    cyc(2);
    rrst = 1'b0;
  endtask
  task automatic wait_frame(input logic [15:0] target);
    for (int i = 0; i < 200 && frame_cnt != target; i++) begin
      cyc(1);
      if (bp) out_ready = ~out_ready;
    end
    chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, target});
    bp = 0;
    out_ready = 1'b1;
    cyc(3);
  endtask
  task automatic wait_pops(input int n);
    for (int i = 0; i < 50 && rinc_n - r0 < n; i++) cyc(1);
    chk("pop_wait", rinc_n - r0, n);
  endtask
  task automatic exp_frame(input logic [7:0] a, b, c, d, cs);
    exp_q.push_back({2'b10, 8'hA5});
    exp_q.push_back({2'b00, 8'h04});
    exp_q.push_back({2'b00, a});
    exp_q.push_back({2'b00, b});
    exp_q.push_back({2'b00, c});
    exp_q.push_back({2'b00, d});
    exp_q.push_back({2'b01, cs});
  endtask
  task automatic check_rx(input string tag);
    chk({tag, "_len"}, rx.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < rx.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {22'd0, rx[base + i]}, {22'd0, exp_q[i]});
    exp_q.delete();
  endtask
  initial begin
    rrst = 1'b1;
    en = 1'b0;
    out_ready = 1'b1;
    cyc(2);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_sof_eof", {out_sof, out_eof}, 2'b00);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    rrst = 1'b0;
    base = rx.size(); r0 = rinc_n;
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    en = 1'b1;
    wait_frame(16'd1);
    exp_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'hF6);
    check_rx("basic");
    chk("basic_rinc", rinc_n - r0, 4);
    chk("basic_busy", busy, 1'b0);
    do_reset;
    base = rx.size(); r0 = rinc_n;
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    bp = 1;
    wait_frame(16'd1);
    exp_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'hF6);
    check_rx("bp");
    chk("bp_rinc", rinc_n - r0, 4);
    chk("bp_hold", bad_hold, 0);
    chk("bp_pop_stalled", bad_pop, 0);
    do_reset;
    base = rx.size(); r0 = rinc_n;
    push(8'h11); push(8'h22);
    wait_pops(2);
    cyc(10);
    push(8'h33); push(8'h44);
    wait_frame(16'd1);
    exp_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h56);
    check_rx("underrun");
    chk("underrun_stall", stall_cnt, 16'd10);
    chk("underrun_pop_empty", bad_empty, 0);
    do_reset;
    base = rx.size(); r0 = rinc_n;
    push4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    wait_frame(16'd2);
    exp_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04);
    exp_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'hF6);
    check_rx("wrap");
    do_reset;
    r0 = rinc_n;
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    push(8'h05); push(8'h06);
    wait_pops(2);
    rrst = 1'b1;
    cyc(1);
    rrst = 1'b0;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_cnts", {frame_cnt, stall_cnt}, 32'd0);
    base = rx.size();
    wait_frame(16'd1);
    exp_frame(8'h03, 8'h04, 8'h05, 8'h06, 8'hEE);
    check_rx("midrst");
    chk("midrst_rinc", rinc_n - r0, 6);
    do_reset;
    en = 1'b0;
    base = rx.size(); r0 = rinc_n;
    push4(8'h10, 8'h20, 8'h30, 8'h40);
    cyc(20);
    chk("en_rinc", rinc_n - r0, 0);
    chk("en_busy", busy, 1'b0);
    chk("en_valid", out_valid, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 3 && !(out_valid && out_sof); i++) cyc(1);
    chk("en_hdr", {out_valid, out_sof, out_data}, {2'b11, 8'hA5});
    wait_frame(16'd1);
    exp_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h60);
    check_rx("en");
    chk("end_hold", bad_hold, 0);
    chk("end_pop_empty", bad_empty, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
